// File: rtl/ffo32_decode_seq.sv
// ffo32_decode_seq: sequential 5-bit index to 32-bit one-hot decoder.
//
// A request is accepted on a posedge where ready=1 and start=1. At that edge
// v/p/accumulate are latched. A one-hot marker is then walked from bit 0
// (leftmost) toward bit 31 under a 5-bit counter until the counter equals the
// latched index. The marker is then written, or ORed, into the held vector b.
//
// Ports:
//   clock       in   system clock, posedge
//   reset       in   synchronous, active-high; clears all state
//   start       in   request strobe, honoured only while ready=1
//   v           in   valid flag; 0 = no bit to set
//   p[0:4]      in   target bit index, 0 selects b[0] (leftmost)
//   accumulate  in   1 = OR into b, 0 = replace b
//   b[0:31]     out  decoded vector, registered
//   ready       out  high only in IDLE
module ffo32_decode_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        v,
  input  logic [0:4]  p,
  input  logic        accumulate,
  output logic [0:31] b,
  output logic        ready
);

  typedef enum logic [3:0] {
    StIdle  = 4'b0001,
    StLoad  = 4'b0010,
    StScan  = 4'b0100,
    StWrite = 4'b1000
  } state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [0:31] r_marker;
  logic [4:0]  r_count;
  logic        r_v;
  logic [0:4]  r_p;
  logic        r_acc;
  logic [0:31] r_b;
  logic        w_scan_done;
  logic [0:31] w_b_next;

  assign w_scan_done = !r_v || (r_count == r_p);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = StIdle;
    case (r_state)
      StIdle:  w_state_next = start ? StLoad : StIdle;
      StLoad:  w_state_next = StScan;
      StScan:  w_state_next = w_scan_done ? StWrite : StScan;
      StWrite: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Moore outputs
  always_comb begin
    ready = (r_state == StIdle);
  end

  assign b = r_b;

  // Value written into b when WRITE completes
  always_comb begin
    w_b_next = r_b;
    if (r_v) begin
      w_b_next = r_acc ? (r_b | r_marker) : r_marker;
    end else if (!r_acc) begin
      w_b_next = '0;
    end
  end

  // Datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_marker <= '0;
      r_count  <= '0;
      r_v      <= 1'b0;
      r_p      <= '0;
      r_acc    <= 1'b0;
      r_b      <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start) begin
            r_v   <= v;
            r_p   <= p;
            r_acc <= accumulate;
          end
        end
        StLoad: begin
          r_marker <= 32'h8000_0000;
          r_count  <= '0;
        end
        StScan: begin
          // Shift toward bit 31 (numerically right), zero fill
          if (!w_scan_done) begin
            r_marker <= r_marker >> 1;
            r_count  <= r_count + 5'd1;
          end
        end
        StWrite: begin
          r_b <= w_b_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ffo32_decode_seq.sv
// Directed testbench for ffo32_decode_seq.
module tb_ffo32_decode_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        v;
  logic [0:4]  p;
  logic        accumulate;
  logic [0:31] b;
  logic        ready;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor counters; written only by the monitor block
  int low_total  = 0;
  int done_total = 0;
  int run_len    = 0;
  int mk_bad     = 0;
  int max_cnt    = 0;
  logic prev_ready = 1'b1;

  ffo32_decode_seq dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .v          (v),
    .p          (p),
    .accumulate (accumulate),
    .b          (b),
    .ready      (ready)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (!ready) begin
      low_total <= low_total + 1;
      // From the first SCAN cycle through WRITE the marker must be one-hot
      if (run_len >= 1 && !$onehot(dut.r_marker)) mk_bad <= mk_bad + 1;
      if (int'(dut.r_count) > max_cnt) max_cnt <= int'(dut.r_count);
      run_len <= run_len + 1;
    end else begin
      run_len <= 0;
    end
    if (ready && !prev_ready) done_total <= done_total + 1;
    prev_ready <= ready;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Wait at negedges until ready is high again, with a cycle budget
  task automatic wait_ready(input string tag);
    int guard;
    guard = 0;
    while (!ready && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (!ready) check({tag, "_timeout"}, 32'(ready), 32'd1);
    #1;
  endtask

  // Issue a request, scramble inputs while busy, and wait for completion
  task automatic run_req(input string tag, input logic vv, input logic [0:4] pp,
                         input logic acc, input int exp_lows, input logic [31:0] exp_b);
    int snap;
    @(negedge clock);
    snap = low_total;
    start = 1'b1; v = vv; p = pp; accumulate = acc;
    @(negedge clock);
    start = 1'b0; v = ~vv; p = ~pp; accumulate = ~acc;
    wait_ready(tag);
    check({tag, "_lows"}, 32'(low_total - snap), 32'(exp_lows));
    check({tag, "_b"}, b, exp_b);
  endtask

  initial begin
    int snap_low;
    int snap_done;
    reset = 1'b1; start = 1'b0; v = 1'b0; p = '0; accumulate = 1'b0;

    // 1: reset
    repeat (2) @(posedge clock);
    #1;
    check("rst_b", b, 32'h0000_0000);
    check("rst_ready", 32'(ready), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("idle_b", b, 32'h0000_0000);
    check("idle_ready", 32'(ready), 32'd1);

    // 2: p=0
    run_req("p0", 1'b1, 5'd0, 1'b0, 3, 32'h8000_0000);

    // 3: p=31, counter reaches 31
    run_req("p31", 1'b1, 5'd31, 1'b0, 34, 32'h0000_0001);
    check("p31_maxcnt", 32'(max_cnt), 32'd31);

    // 4: accumulate sequence
    run_req("p3", 1'b1, 5'd3, 1'b0, 6, 32'h1000_0000);
    run_req("p5acc", 1'b1, 5'd5, 1'b1, 8, 32'h1400_0000);
    run_req("v0acc", 1'b0, 5'd7, 1'b1, 3, 32'h1400_0000);
    run_req("v0clr", 1'b0, 5'd9, 1'b0, 3, 32'h0000_0000);

    // 5: start pulse and p change during SCAN are ignored
    @(negedge clock);
    snap_low = low_total;
    snap_done = done_total;
    start = 1'b1; v = 1'b1; p = 5'd10; accumulate = 1'b0;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    start = 1'b1; p = 5'd2;
    @(negedge clock);
    start = 1'b0;
    wait_ready("busy");
    check("busy_lows", 32'(low_total - snap_low), 32'd13);
    check("busy_b", b, 32'h0020_0000);
    repeat (3) @(negedge clock);
    #1;
    check("busy_done", 32'(done_total - snap_done), 32'd1);
    check("busy_ready", 32'(ready), 32'd1);
    check("busy_b_hold", b, 32'h0020_0000);

    // 6: reset mid-scan
    @(negedge clock);
    start = 1'b1; v = 1'b1; p = 5'd20; accumulate = 1'b0;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    check("abort_busy", 32'(ready), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_b", b, 32'h0000_0000);
    check("abort_cnt", 32'(dut.r_count), 32'd0);
    run_req("p1", 1'b1, 5'd1, 1'b0, 4, 32'h4000_0000);

    check("marker_onehot", 32'(mk_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
